// File: rtl/pg_prefix_adder_pipe.sv
// Pipelined Kogge-Stone prefix adder with carry-in and group G/P outputs.
// Per-bit generate/propagate cells feed a log2(WIDTH)-level prefix tree.
// Each prefix level can optionally be registered. A valid/ready stream
// interface with a single global advance enable provides backpressure.
// Every stage carries a valid bit. The whole pipe holds while the output
// beat is waiting for the consumer.
module pg_prefix_adder_pipe #(
  parameter int WIDTH      = 8,
  parameter int REG_LEVELS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             grp_g,
  output logic             grp_p
);

  localparam int LV = $clog2(WIDTH);

  // The prefix tree only closes cleanly over a power-of-two span.
  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pg_prefix_adder_pipe: WIDTH must be a power of 2 and >= 2");
  end

  // Global advance. All stages move together or all stages hold. The
  // output register can always take a new beat when it is empty or
  // being consumed, so the upstream stages can move in that case as well.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------
  // Stage 0: operand capture
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             cin_q;
  logic             v0_q;

  // Capture an accepted beat. A bubble loads zeros so that no stage ever
  // carries stale or unknown data.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data registers are reset as well as valid bits. Outputs are
    // then defined zeros after reset, and bubbles never carry X.
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      cin_q <= 1'b0;
      v0_q  <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking assignments let every stage sample the value
      // its predecessor had before this edge, which is what a shift needs.
      v0_q <= in_valid;
      if (in_valid) begin
        x_q   <= x;
        y_q   <= y;
        cin_q <= cin;
      end else begin
        x_q   <= '0;
        y_q   <= '0;
        cin_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Prefix tree
  // ---------------------------------------------------------------------
  // lvl[0] holds the per-bit cells. lvl[l] holds group (G,P) over span
  // 2^l ending at each bit. The raw per-bit propagate (bp), the carry-in
  // (c) and the valid bit (v) travel alongside. After the last level,
  // g[i]/p[i] are the group G/P over bits i..0, and cin is excluded.
  for (genvar l = 0; l <= LV; l++) begin : lvl
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] bp;
    logic             c;
    logic             v;

    if (l == 0) begin : g_cell
      assign g  = x_q & y_q;
      assign p  = x_q ^ y_q;
      assign bp = x_q ^ y_q;
      assign c  = cin_q;
      assign v  = v0_q;
    end else begin : g_tree
      localparam int SPAN = 1 << (l - 1);
      // Bits below SPAN have no partner at this level and pass through.
      localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - SPAN);

      logic [WIDTH-1:0] g_nx;
      logic [WIDTH-1:0] p_nx;

      // Apply (G,P)hi o (G,P)lo = (Ghi | Phi&Glo, Phi&Plo) across SPAN.
      always_comb begin
        g_nx = lvl[l-1].g | (lvl[l-1].p & (lvl[l-1].g << SPAN));
        p_nx = lvl[l-1].p & ((lvl[l-1].p << SPAN) | LOW_MASK);
      end

      if (REG_LEVELS != 0) begin : g_reg
        // Register this prefix level and shift it with the rest of the pipe.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            g  <= '0;
            p  <= '0;
            bp <= '0;
            c  <= 1'b0;
            v  <= 1'b0;
          end else if (adv) begin
            g  <= g_nx;
            p  <= p_nx;
            bp <= lvl[l-1].bp;
            c  <= lvl[l-1].c;
            v  <= lvl[l-1].v;
          end
        end
      end else begin : g_comb
        assign g  = g_nx;
        assign p  = p_nx;
        assign bp = lvl[l-1].bp;
        assign c  = lvl[l-1].c;
        assign v  = lvl[l-1].v;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Carry resolution and output stage
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] tree_g;
  logic [WIDTH-1:0] tree_p;
  logic [WIDTH-1:0] tree_bp;
  logic             tree_c;
  logic             tree_v;

  assign tree_g  = lvl[LV].g;
  assign tree_p  = lvl[LV].p;
  assign tree_bp = lvl[LV].bp;
  assign tree_c  = lvl[LV].c;
  assign tree_v  = lvl[LV].v;

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  // Fold cin in as position -1 with (G,P) = (cin,0). The last prefix
  // step for each bit is therefore carry[i] = G[i-1:0] | P[i-1:0] & cin.
  always_comb begin
    carry  = {tree_g[WIDTH-2:0] | (tree_p[WIDTH-2:0] & {(WIDTH-1){tree_c}}), tree_c};
    sum_d  = tree_bp ^ carry;
    cout_d = tree_g[WIDTH-1] | (tree_p[WIDTH-1] & tree_c);
  end

  // Output register. It holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      grp_g     <= 1'b0;
      grp_p     <= 1'b0;
    end else if (adv) begin
      out_valid <= tree_v;
      sum       <= sum_d;
      cout      <= cout_d;
      grp_g     <= tree_g[WIDTH-1];
      grp_p     <= tree_p[WIDTH-1];
    end
  end

endmodule
